// File: rtl/instr_fetch_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction prefetch path.
package instr_fetch_pkg;
    localparam int ADDR_W = 10;
    localparam int WORD_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush clears it in one cycle.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);
    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetch in front of a 1-cycle-latency ROM, with redirect flush.
module instr_prefetch_unit
    import instr_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    input  logic [WORD_W-1:0] rom_readdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              issue;
    fetch_entry_t      head;
    fetch_entry_t      ret_entry;

    assign instr_valid = ~empty;
    assign pop         = instr_valid & instr_ready & ~redirect_valid;
    assign push        = inflight & ~redirect_valid;

    // A read is only launched if its return is guaranteed a slot next cycle.
    assign occupancy = OCC_W'(count) - OCC_W'(pop) + OCC_W'(inflight);
    assign issue     = ~reset & ~redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));

    assign rom_address    = fetch_pc;
    assign rom_chipselect = issue;
    assign rom_clken      = 1'b1;

    assign ret_entry = '{pc: inflight_pc, instr: rom_readdata};

    // Stale storage is masked so an empty buffer presents zeros.
    assign instr_data = empty ? '0 : head.instr;
    assign instr_pc   = empty ? '0 : head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (ret_entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && full && !pop));
    end
endmodule
